// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types for the data-memory arbiter
package dmem_arb_pkg;

   // Arbitration mode: normal round-robin or debug-owned burst
   typedef enum logic {
      ARB    = 1'b0,
      LOCKED = 1'b1
   } arb_state_t;

   // Which requester owns the tie-break on the next contended cycle
   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_DBG = 1'b1
   } owner_t;

endpackage

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares single-port dmem between core MEM stage and debug port
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 32,
   parameter int MAX_LOCK = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic              dbg_lock,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              dbg_ack,
   output logic              lock_timeout,
   output logic              mem_wr_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wr_data,
   input  logic [DATA_W-1:0] mem_rd_data
);

   localparam int             CNT_W    = $clog2(MAX_LOCK);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_LOCK - 1);

   arb_state_t        state_q, state_d;
   owner_t            prio_q, prio_d;
   logic              pending_q, pending_d;
   logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
   logic              lock_timeout_q, lock_timeout_d;
   logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;

   logic              dbg_elig;
   logic              contended;
   logic              cpu_grant;
   logic              dbg_grant;

   // The ack cycle is never a grant cycle, so a debug request is only eligible when no ack is due
   assign dbg_elig = dbg_req & ~pending_q;

   // Pick the winner; rst low suppresses every grant so no write lands while reset is asserted
   always_comb begin
      contended = 1'b0;
      cpu_grant = 1'b0;
      dbg_grant = 1'b0;
      if (rst) begin
         if (state_q == LOCKED) begin
            dbg_grant = dbg_elig;
         end else begin
            contended = cpu_req & dbg_elig;
            if (contended) begin
               dbg_grant = (prio_q == OWN_DBG);
               cpu_grant = (prio_q == OWN_CPU);
            end else begin
               dbg_grant = dbg_elig;
               cpu_grant = cpu_req;
            end
         end
      end
   end

   // Next-state: priority rotation, lock entry/exit, lock timer and debug read capture
   always_comb begin
      state_d        = state_q;
      prio_d         = prio_q;
      pending_d      = dbg_grant;
      lock_cnt_d     = lock_cnt_q;
      lock_timeout_d = lock_timeout_q;
      dbg_rdata_d    = dbg_rdata_q;

      if (dbg_grant) begin
         dbg_rdata_d = mem_rd_data;
      end

      if (state_q == ARB) begin
         if (contended) begin
            prio_d = cpu_grant ? OWN_DBG : OWN_CPU;
         end
         if (dbg_grant && dbg_lock && !lock_timeout_q) begin
            state_d    = LOCKED;
            lock_cnt_d = '0;
         end
      end else begin
         lock_cnt_d = lock_cnt_q + 1'b1;
         if (!dbg_lock) begin
            state_d    = ARB;
            prio_d     = OWN_CPU;
            lock_cnt_d = '0;
         end else if (lock_cnt_q == CNT_LAST) begin
            state_d        = ARB;
            prio_d         = OWN_CPU;
            lock_cnt_d     = '0;
            lock_timeout_d = 1'b1;
         end
      end

      // A timed-out lock stays disarmed until the debugger lets go of dbg_lock
      if (!dbg_lock) begin
         lock_timeout_d = 1'b0;
      end
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= ARB;
         prio_q         <= OWN_CPU;
         pending_q      <= 1'b0;
         lock_cnt_q     <= '0;
         lock_timeout_q <= 1'b0;
         dbg_rdata_q    <= '0;
      end else begin
         state_q        <= state_d;
         prio_q         <= prio_d;
         pending_q      <= pending_d;
         lock_cnt_q     <= lock_cnt_d;
         lock_timeout_q <= lock_timeout_d;
         dbg_rdata_q    <= dbg_rdata_d;
      end
   end

   assign cpu_stall    = rst & cpu_req & ~cpu_grant;
   assign cpu_rdata    = mem_rd_data;
   assign mem_addr     = dbg_grant ? dbg_addr  : cpu_addr;
   assign mem_wr_data  = dbg_grant ? dbg_wdata : cpu_wdata;
   assign mem_wr_en    = (cpu_grant & cpu_we) | (dbg_grant & dbg_we);
   assign dbg_ack      = pending_q;
   assign dbg_rdata    = dbg_rdata_q;
   assign lock_timeout = lock_timeout_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

   localparam int MAX_LOCK = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cpu_req = 1'b0;
   logic        cpu_we = 1'b0;
   logic [31:0] cpu_addr = '0;
   logic [31:0] cpu_wdata = '0;
   logic [31:0] cpu_rdata;
   logic        cpu_stall;
   logic        dbg_req = 1'b0;
   logic        dbg_we = 1'b0;
   logic        dbg_lock = 1'b0;
   logic [31:0] dbg_addr = '0;
   logic [31:0] dbg_wdata = '0;
   logic [31:0] dbg_rdata;
   logic        dbg_ack;
   logic        lock_timeout;
   logic        mem_wr_en;
   logic [31:0] mem_addr;
   logic [31:0] mem_wr_data;
   logic [31:0] mem_rd_data;

   int errors = 0;
   int checks = 0;

   dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .MAX_LOCK(MAX_LOCK)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_lock(dbg_lock), .dbg_addr(dbg_addr),
      .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
      .lock_timeout(lock_timeout),
      .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
      .mem_rd_data(mem_rd_data)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] init_val(int i);
      return 32'h5A00_0000 + 32'(i) * 32'h0001_0203;
   endfunction

   // Bench-side dmem: combinational read, write at posedge
   logic [31:0] dmem [0:63];
   logic [31:0] shadow [0:63];
   initial begin
      for (int i = 0; i < 64; i++) begin
         dmem[i]   = init_val(i);
         shadow[i] = init_val(i);
      end
   end
   assign mem_rd_data = dmem[mem_addr[7:2]];
   always @(posedge clk) if (mem_wr_en) dmem[mem_addr[7:2]] <= mem_wr_data;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model state
   bit          m_locked = 0;
   bit          m_dbg_turn = 0;
   bit          m_ack_due = 0;
   int          m_lock_cycles = 0;
   bit          m_timeout = 0;
   logic [31:0] m_rdata = '0;

   always @(negedge clk) begin : model
      logic        elig, g_cpu, g_dbg, contend, e_we;
      logic [31:0] e_addr, e_wdata;
      if (!rst) begin
         m_locked = 0; m_dbg_turn = 0; m_ack_due = 0;
         m_lock_cycles = 0; m_timeout = 0; m_rdata = '0;
         chk("m_rst_stall", 32'(cpu_stall), 32'd0);
         chk("m_rst_wen",   32'(mem_wr_en), 32'd0);
         chk("m_rst_ack",   32'(dbg_ack), 32'd0);
         chk("m_rst_to",    32'(lock_timeout), 32'd0);
         chk("m_rst_rdata", dbg_rdata, 32'd0);
      end else begin
         elig    = dbg_req && !m_ack_due;
         contend = 1'b0;
         if (m_locked) begin
            g_dbg = elig; g_cpu = 1'b0;
         end else if (cpu_req && elig) begin
            contend = 1'b1; g_dbg = m_dbg_turn; g_cpu = !m_dbg_turn;
         end else begin
            g_dbg = elig; g_cpu = cpu_req;
         end
         e_addr  = g_dbg ? dbg_addr  : cpu_addr;
         e_wdata = g_dbg ? dbg_wdata : cpu_wdata;
         e_we    = g_dbg ? dbg_we : (g_cpu & cpu_we);

         chk("m_stall", 32'(cpu_stall), 32'(cpu_req && !g_cpu));
         chk("m_wen",   32'(mem_wr_en), 32'(e_we));
         chk("m_addr",  mem_addr, e_addr);
         chk("m_wdata", mem_wr_data, e_wdata);
         chk("m_ack",   32'(dbg_ack), 32'(m_ack_due));
         chk("m_to",    32'(lock_timeout), 32'(m_timeout));
         if (m_ack_due) chk("m_dbg_rdata", dbg_rdata, m_rdata);
         if (g_cpu)     chk("m_cpu_rdata", cpu_rdata, shadow[cpu_addr[7:2]]);

         if (g_dbg) m_rdata = shadow[dbg_addr[7:2]];
         if (e_we)  shadow[e_addr[7:2]] = e_wdata;
         m_ack_due = g_dbg;
         if (!m_locked) begin
            if (contend) m_dbg_turn = g_cpu;
            if (g_dbg && dbg_lock && !m_timeout) begin
               m_locked = 1; m_lock_cycles = 0;
            end
         end else begin
            m_lock_cycles++;
            if (!dbg_lock) begin
               m_locked = 0; m_dbg_turn = 0;
            end else if (m_lock_cycles == MAX_LOCK) begin
               m_locked = 0; m_dbg_turn = 0; m_timeout = 1;
            end
         end
         if (!dbg_lock) m_timeout = 0;
      end
   end

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic at_neg();
      @(negedge clk); #1;
   endtask

   initial begin
      // Reset with core requesting a store: stall and write must stay low
      cpu_req = 1; cpu_we = 1; cpu_addr = 32'h20; cpu_wdata = 32'h11;
      repeat (2) cyc();
      at_neg();
      chk("rst_stall", 32'(cpu_stall), 32'd0);
      chk("rst_wen",   32'(mem_wr_en), 32'd0);
      chk("rst_ack",   32'(dbg_ack), 32'd0);

      // Core only: store then load
      cyc(); rst = 1; cpu_wdata = 32'hDEAD_BEEF;
      at_neg();
      chk("core_wr_stall", 32'(cpu_stall), 32'd0);
      chk("core_wr_en",    32'(mem_wr_en), 32'd1);
      cyc(); cpu_we = 0;
      at_neg();
      chk("core_rd_stall", 32'(cpu_stall), 32'd0);
      chk("core_rd_data",  cpu_rdata, 32'hDEAD_BEEF);

      // Debug only: write then read of 0x40
      cyc(); cpu_req = 0; dbg_req = 1; dbg_we = 1; dbg_addr = 32'h40; dbg_wdata = 32'h1234;
      at_neg();
      chk("dbg_wr_en", 32'(mem_wr_en), 32'd1);
      cyc(); dbg_we = 0;
      at_neg();
      chk("dbg_wr_ack", 32'(dbg_ack), 32'd1);
      cyc();
      at_neg();
      chk("dbg_rd_noack", 32'(dbg_ack), 32'd0);
      cyc(); dbg_req = 0;
      at_neg();
      chk("dbg_rd_ack",   32'(dbg_ack), 32'd1);
      chk("dbg_rd_data",  dbg_rdata, 32'h1234);

      // Contention: CPU, DBG, CPU(ack), ...
      cyc(); cpu_req = 1; dbg_req = 1; dbg_we = 0; cpu_we = 0;
      at_neg(); chk("cont0_stall", 32'(cpu_stall), 32'd0);
      cyc(); at_neg(); chk("cont1_stall", 32'(cpu_stall), 32'd1);
      cyc(); at_neg(); chk("cont2_stall", 32'(cpu_stall), 32'd0);
      chk("cont2_ack", 32'(dbg_ack), 32'd1);
      for (int k = 0; k < 6; k++) begin
         cyc();
         cpu_addr = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
         dbg_addr = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      end

      // Lock: 3 debug writes with core held off, then release
      cyc(); dbg_lock = 1; dbg_we = 1; dbg_wdata = 32'hA0;
      at_neg(); chk("lock_pre_stall", 32'(cpu_stall), 32'd0);
      for (int k = 0; k < 6; k++) begin
         cyc(); dbg_wdata = dbg_wdata + 32'd1;
         at_neg(); chk("lock_stall", 32'(cpu_stall), 32'd1);
      end
      cyc(); dbg_lock = 0; dbg_req = 0;
      at_neg(); chk("lock_drop_stall", 32'(cpu_stall), 32'd1);
      cyc(); at_neg(); chk("lock_after_stall", 32'(cpu_stall), 32'd0);

      // Timeout: lock held continuously
      for (int k = 0; k < 10; k++) begin
         cyc(); dbg_req = 1; dbg_lock = 1; dbg_we = 0;
         at_neg();
         if (k == 9) begin
            chk("to_last_stall", 32'(cpu_stall), 32'd1);
            chk("to_last_flag",  32'(lock_timeout), 32'd0);
         end
      end
      cyc(); at_neg();
      chk("to_flag",  32'(lock_timeout), 32'd1);
      chk("to_stall", 32'(cpu_stall), 32'd0);
      cyc(); dbg_lock = 0;
      at_neg(); chk("to_hold", 32'(lock_timeout), 32'd1);
      cyc(); at_neg(); chk("to_clear", 32'(lock_timeout), 32'd0);

      // Async reset in the middle of a debug write grant
      cyc(); cpu_req = 0; dbg_req = 0;
      cyc(); dbg_req = 1; dbg_we = 1; dbg_addr = 32'h80; dbg_wdata = 32'hCAFE_F00D;
      #2 rst = 0;
      at_neg();
      chk("ar_wen", 32'(mem_wr_en), 32'd0);
      cyc(); at_neg();
      chk("ar_ack",  32'(dbg_ack), 32'd0);
      chk("ar_mem",  dmem[32], init_val(32));
      chk("ar_rdata", dbg_rdata, 32'd0);
      cyc(); rst = 1; dbg_req = 0; dbg_we = 0;

      // Randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         cyc();
         if (!rst) rst = 1;
         cpu_req   = ($urandom_range(0, 99) < 60);
         cpu_we    = 1'($urandom_range(0, 1));
         cpu_addr  = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
         cpu_wdata = $urandom;
         dbg_req   = ($urandom_range(0, 99) < 50);
         dbg_we    = 1'($urandom_range(0, 1));
         dbg_addr  = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
         dbg_wdata = $urandom;
         if ($urandom_range(0, 99) < 6) dbg_lock = ~dbg_lock;
         if ($urandom_range(0, 499) == 0) begin
            #2 rst = 0;
         end
      end
      cyc(); rst = 1;
      at_neg();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port data memory between the processor's MEM stage and a debug/loader port. The block sits between the `arm` core, the debug requester and `dmem` inside `top`. It arbitrates round-robin on contention and stalls the core when the core loses. It also supports a bounded exclusive "lock" mode, so the debug port can run back-to-back bursts with the core held off.

## Interface
Parameters:
- DATA_W, 32, data width of all data buses
- ADDR_W, 32, address width
- MAX_LOCK, 64, maximum consecutive cycles in LOCKED before forced release (≥2)

Ports:
- clk  in  1  system clock, all state on posedge
- rst  in  1  asynchronous, active-low reset
- cpu_req  in  1  core MEM stage wants memory this cycle (load or store)
- cpu_we  in  1  core store (MemWriteM)
- cpu_addr  in  ADDR_W  core address (ALUOutM)
- cpu_wdata  in  DATA_W  core store data (WriteDataM)
- cpu_rdata  out  DATA_W  load data to core (ReadDataM)
- cpu_stall  out  1  freeze core pipeline this cycle
- dbg_req  in  1  debug access request, held until dbg_ack
- dbg_we  in  1  debug write
- dbg_lock  in  1  request exclusive ownership
- dbg_addr  in  ADDR_W  debug address
- dbg_wdata  in  DATA_W  debug write data
- dbg_rdata  out  DATA_W  registered read data, valid with dbg_ack
- dbg_ack  out  1  one-cycle completion pulse
- lock_timeout  out  1  sticky: LOCKED ended by MAX_LOCK expiry
- mem_wr_en  out  1  to dmem wr_en
- mem_addr  out  ADDR_W  to dmem addr
- mem_wr_data  out  DATA_W  to dmem wr_data
- mem_rd_data  in  DATA_W  from dmem rd_data (combinational read)

## Operation
- Registered state:
  - state ∈ {ARB, LOCKED}
  - prio ∈ {CPU, DBG}
  - pending: debug granted last cycle, ack due
  - lock_cnt
  - lock_timeout
  - dbg_rdata
- Debug eligibility: dbg_req=1 and pending=0. The ack cycle is never a grant cycle, so the debug port gets at most one access per 2 cycles.
- Grant in ARB (combinational):
  - only one requester eligible → it wins.
  - both eligible → the prio owner wins.
  - after a contended grant, prio flips to the loser.
- Grant in LOCKED: an eligible debug request always wins; the core never wins.
- cpu_stall = cpu_req & ~cpu_grant. cpu_req must not depend on cpu_stall.
- Memory mux:
  - mem_addr/mem_wr_data follow the granted requester; the core is the default when idle.
  - mem_wr_en = granted requester's we; 0 when no grant.
- cpu_rdata = mem_rd_data, always.
- Debug grant: next cycle pending=1, dbg_ack=1, dbg_rdata ← mem_rd_data sampled at the grant edge. The write commits at that same edge.
- ARB→LOCKED: on a debug grant with dbg_lock=1 and lock_timeout=0. lock_cnt←0.
- LOCKED→ARB on whichever comes first:
  - dbg_lock=0 → prio←CPU.
  - lock_cnt==MAX_LOCK-1 → prio←CPU, lock_timeout←1.
- lock_cnt increments every LOCKED cycle, including idle cycles.
- lock_timeout clears on the first cycle dbg_lock=0. While it is set, dbg_lock is ignored and the debug port arbitrates normally.

## Timing
- Reset (rst=0, async):
  - state=ARB, prio=CPU, pending=0, lock_cnt=0, lock_timeout=0
  - dbg_ack=0, dbg_rdata=0
  - mem_wr_en forced 0, cpu_stall forced 0
- Core access latency: 0 cycles when granted. A read returns the same cycle; a write commits at the end of the cycle.
- Debug latency: grant at cycle N, dbg_ack at N+1. The earliest next grant is N+2, provided dbg_req is held with new fields during the ack cycle.
- Worst-case core wait in ARB is 1 cycle. In LOCKED the core waits up to MAX_LOCK cycles.
- Reset asserted mid-access: a pending ack is dropped (no dbg_ack), and an uncommitted write is not performed.
- dbg_req dropped before grant: the request is withdrawn, with no ack and no side effect.

## Structure
- Package dmem_arb_pkg holds:
  - typedef enum arb_state_t {ARB, LOCKED}
  - typedef enum owner_t {OWN_CPU, OWN_DBG}
- Single module; no sub-module needed. The lock counter stays inline, width $clog2(MAX_LOCK).

## Test plan
- Core only: cpu_req=1, cpu_we=1, addr 0x20, data 0xDEADBEEF; then a load from 0x20 → cpu_stall=0 throughout, cpu_rdata=0xDEADBEEF on the load cycle.
- Debug only: dbg write 0x40←0x1234, then read 0x40 → dbg_ack on the cycle after each grant, grants 2 cycles apart, dbg_rdata=0x1234.
- Contention: cpu_req and dbg_req both held high from reset release → grants follow CPU, DBG, CPU, …; cpu_stall high exactly on DBG-grant cycles. The ack cycle always goes to the CPU.
- Lock: dbg_lock=1 with 3 debug writes while cpu_req=1 → cpu_stall high for all 6 cycles. Drop dbg_lock → the core is granted on the next cycle.
- Timeout: MAX_LOCK=8, dbg_lock held high continuously → back to ARB after 8 LOCKED cycles, lock_timeout=1 and the core is granted. Drop dbg_lock for 1 cycle → lock_timeout=0.
- Async reset during a debug grant cycle → no dbg_ack, the memory location is unchanged, all outputs at reset values.
